// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, constants and pipeline stage payloads for the FP16 subtractor.
package fp16_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned EXP_BITS = 5;
  localparam int unsigned MAN_BITS = 10;
  localparam int unsigned DP_BITS  = 14;
  localparam int unsigned BIAS     = 15;
  localparam int unsigned EXP_MAX  = 2 * BIAS;

  localparam logic [WIDTH-1:0] FP16_QNAN = 16'h7E00;
  localparam logic [WIDTH-1:0] FP16_MAXF = 16'h7BFF;

  typedef struct packed {
    logic                sign;
    logic [EXP_BITS-1:0] exponent;
    logic [MAN_BITS-1:0] mantissa;
  } fp16_t;

  // Aligned operands: man_l/man_s are hidden+mantissa+G+R+S
  typedef struct packed {
    logic                sign;
    logic                eff_sub;
    logic [EXP_BITS-1:0] exp;
    logic [DP_BITS-1:0]  man_l;
    logic [DP_BITS-1:0]  man_s;
    logic                special;
    logic [WIDTH-1:0]    special_val;
  } s1_t;

  typedef struct packed {
    logic                sign;
    logic [EXP_BITS-1:0] exp;
    logic [DP_BITS:0]    sum;
    logic                special;
    logic [WIDTH-1:0]    special_val;
  } s2_t;

endpackage

// File: rtl/fp16_sub_pipe_if.sv
// Operand/result handshake bundle for the FP16 subtractor.
interface fp16_sub_pipe_if
  import fp16_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 4
);

  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [1:0][WIDTH-1:0]     operands_i;
  logic [TAG_WIDTH-1:0]      tag_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [WIDTH-1:0]          result_o;
  logic [TAG_WIDTH-1:0]      tag_o;

  modport slave (
    input  in_valid_i, operands_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o
  );

  modport master (
    output in_valid_i, operands_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o
  );

endinterface

// File: rtl/fp16_norm_lzc.sv
// Leading-zero count of the 15-bit sum used for post-add normalisation.
module fp16_norm_lzc
  import fp16_pkg::*;
(
  input  logic [DP_BITS:0] i_data,
  output logic [3:0]       o_count,
  output logic             o_empty
);

  logic w_found;

  always_comb begin
    w_found = 1'b0;
    o_count = '0;
    for (int i = int'(DP_BITS); i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        w_found = 1'b1;
        o_count = 4'(int'(DP_BITS) - i);
      end
    end
  end

  assign o_empty = !w_found;

endmodule

// File: rtl/fp16_sub_pipe.sv
// Three-stage FP16 subtractor (a - b), round-toward-zero, with valid/ready flow control and a sideband tag.
module fp16_sub_pipe
  import fp16_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 4
)
(
  input  logic            clk_i,
  input  logic            rst_ni,
  fp16_sub_pipe_if.slave  bus
);

  localparam int unsigned NORM_W = MAN_BITS + 1;

  fp16_t                w_a, w_b;
  logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_ge, w_sticky;
  logic [EXP_BITS-1:0]  w_ea, w_eb, w_el, w_es, w_diff;
  logic [MAN_BITS:0]    w_ma, w_mb, w_ml, w_ms;
  logic [DP_BITS-1:0]   w_sv, w_shift;
  s1_t                  w_s1, r_s1;
  s2_t                  w_s2, r_s2;
  logic                 r_s1_valid, r_s2_valid, r_s3_valid;
  logic                 w_s1_adv, w_s2_adv, w_s3_adv;
  logic [TAG_WIDTH-1:0] r_s1_tag, r_s2_tag, r_s3_tag;
  logic [3:0]           w_lz;
  logic                 w_lz_empty;
  logic [EXP_BITS-1:0]  w_sh, w_sh_lz, w_sh_e, w_e_norm;
  logic [EXP_BITS:0]    w_e_inc;
  logic [NORM_W-1:0]    w_norm;
  logic [WIDTH-1:0]     w_res, r_result;

  // Stage advance chain; in_ready looks through to out_ready
  assign w_s3_adv       = !r_s3_valid || bus.out_ready_i;
  assign w_s2_adv       = !r_s2_valid || w_s3_adv;
  assign w_s1_adv       = !r_s1_valid || w_s2_adv;
  assign bus.in_ready_o = w_s1_adv;

  assign w_a     = bus.operands_i[1];
  assign w_b     = bus.operands_i[0];
  assign w_a_nan = (&w_a.exponent) && (|w_a.mantissa);
  assign w_b_nan = (&w_b.exponent) && (|w_b.mantissa);
  assign w_a_inf = (&w_a.exponent) && !(|w_a.mantissa);
  assign w_b_inf = (&w_b.exponent) && !(|w_b.mantissa);
  assign w_a_ge  = {w_a.exponent, w_a.mantissa} >= {w_b.exponent, w_b.mantissa};
  assign w_ea    = (|w_a.exponent) ? w_a.exponent : EXP_BITS'(1);
  assign w_eb    = (|w_b.exponent) ? w_b.exponent : EXP_BITS'(1);
  assign w_ma    = {|w_a.exponent, w_a.mantissa};
  assign w_mb    = {|w_b.exponent, w_b.mantissa};

  // Stage 1: swap by magnitude, align the smaller operand with sticky, resolve specials
  always_comb begin
    w_s1     = '0;
    w_el     = w_eb;
    w_es     = w_ea;
    w_ml     = w_mb;
    w_ms     = w_ma;
    w_diff   = '0;
    w_sv     = '0;
    w_shift  = '0;
    w_sticky = 1'b0;
    w_s1.sign = ~w_b.sign;
    if (w_a_ge) begin
      w_el      = w_ea;
      w_es      = w_eb;
      w_ml      = w_ma;
      w_ms      = w_mb;
      w_s1.sign = w_a.sign;
    end
    w_diff = w_el - w_es;
    w_sv   = {w_ms, 3'b000};
    if (w_diff >= EXP_BITS'(DP_BITS)) begin
      w_sticky = |w_ms;
    end else begin
      w_shift  = w_sv >> w_diff;
      w_sticky = |(w_sv & DP_BITS'((DP_BITS'(1) << w_diff) - DP_BITS'(1)));
    end
    w_s1.exp     = w_el;
    w_s1.man_l   = {w_ml, 3'b000};
    w_s1.man_s   = {w_shift[DP_BITS-1:1], w_shift[0] | w_sticky};
    w_s1.eff_sub = w_a.sign ^ ~w_b.sign;
    if (w_a_nan || w_b_nan) begin
      w_s1.special     = 1'b1;
      w_s1.special_val = FP16_QNAN;
    end else if (w_a_inf && w_b_inf) begin
      w_s1.special     = 1'b1;
      w_s1.special_val = (w_a.sign == w_b.sign) ? FP16_QNAN : w_a;
    end else if (w_a_inf) begin
      w_s1.special     = 1'b1;
      w_s1.special_val = w_a;
    end else if (w_b_inf) begin
      w_s1.special     = 1'b1;
      w_s1.special_val = {~w_b.sign, w_b.exponent, w_b.mantissa};
    end else if (w_a == 16'h8000 && w_b == 16'h0000) begin
      // -0 - +0 is the one exact zero that keeps a negative sign
      w_s1.special     = 1'b1;
      w_s1.special_val = 16'h8000;
    end
  end

  // Stage 2: magnitude add/subtract, larger operand always on the left
  always_comb begin
    w_s2             = '0;
    w_s2.sign        = r_s1.sign;
    w_s2.exp         = r_s1.exp;
    w_s2.special     = r_s1.special;
    w_s2.special_val = r_s1.special_val;
    w_s2.sum         = r_s1.eff_sub ? ({1'b0, r_s1.man_l} - {1'b0, r_s1.man_s})
                                    : ({1'b0, r_s1.man_l} + {1'b0, r_s1.man_s});
  end

  fp16_norm_lzc u_lzc (
    .i_data  (r_s2.sum),
    .o_count (w_lz),
    .o_empty (w_lz_empty)
  );

  // Stage 3: normalise (left shift clamped at exponent 1), truncate, saturate on overflow
  always_comb begin
    w_e_inc  = {1'b0, r_s2.exp} + (EXP_BITS+1)'(1);
    w_sh_lz  = EXP_BITS'(w_lz) - EXP_BITS'(1);
    w_sh_e   = r_s2.exp - EXP_BITS'(1);
    w_sh     = (w_sh_lz < w_sh_e) ? w_sh_lz : w_sh_e;
    w_e_norm = r_s2.exp - w_sh;
    w_norm   = NORM_W'((DP_BITS+1)'(r_s2.sum << w_sh) >> 3);
    w_res    = '0;
    if (r_s2.special) begin
      w_res = r_s2.special_val;
    end else if (r_s2.sum[DP_BITS]) begin
      if (w_e_inc > (EXP_BITS+1)'(EXP_MAX))
        w_res = {r_s2.sign, FP16_MAXF[WIDTH-2:0]};
      else
        w_res = {r_s2.sign, w_e_inc[EXP_BITS-1:0], r_s2.sum[DP_BITS-1:4]};
    end else if (!w_lz_empty) begin
      w_res = {r_s2.sign, w_norm[MAN_BITS] ? w_e_norm : {EXP_BITS{1'b0}},
               w_norm[MAN_BITS-1:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s1_tag   <= '0;
      r_s2_tag   <= '0;
      r_s3_tag   <= '0;
      r_result   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid_i;
        if (bus.in_valid_i) begin
          r_s1     <= w_s1;
          r_s1_tag <= bus.tag_i;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2     <= w_s2;
          r_s2_tag <= r_s1_tag;
        end
      end
      if (w_s3_adv) begin
        r_s3_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_result <= w_res;
          r_s3_tag <= r_s2_tag;
        end
      end
    end
  end

  assign bus.out_valid_o = r_s3_valid;
  assign bus.result_o    = r_result;
  assign bus.tag_o       = r_s3_tag;

endmodule

// File: tb/tb_fp16_sub_pipe.sv
// Directed bench for fp16_sub_pipe: scoreboard of expected results, checked as outputs leave the pipe.
module tb_fp16_sub_pipe;

  logic clk = 1'b0;
  logic rst_ni;

  fp16_sub_pipe_if #(.TAG_WIDTH(4)) bus ();

  fp16_sub_pipe #(.TAG_WIDTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
    int          cyc;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         e_mon;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_out = 0;
  int          n0;
  logic [15:0] exp_res = '0;
  logic        toggle = 1'b0;
  logic        chk_lat = 1'b0;

  logic [15:0] dir_a [16] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h0400, 16'h3C00, 16'h3C00,
                              16'h7BFF, 16'h7C00, 16'h7C00, 16'h3C00, 16'h7E01, 16'hC000,
                              16'h3555, 16'hFC00, 16'h0000, 16'h7C00};
  logic [15:0] dir_b [16] = '{16'h3800, 16'h3C00, 16'h0000, 16'h0001, 16'h0001, 16'hBC00,
                              16'hFBFF, 16'h7C00, 16'h3C00, 16'h7C00, 16'h0000, 16'h3C00,
                              16'h3554, 16'hFC00, 16'h8000, 16'hFC00};
  logic [15:0] dir_r [16] = '{16'h3800, 16'h0000, 16'h8000, 16'h03FF, 16'h3BFF, 16'h4000,
                              16'h7BFF, 16'h7E00, 16'h7C00, 16'hFC00, 16'h7E00, 16'hC200,
                              16'h0C00, 16'h7E00, 16'h0000, 16'h7C00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, got, want);
    end
  endtask

  // Transfers are decided at the next rising edge; at the falling edge everything is settled
  always @(negedge clk) begin
    if (rst_ni) begin
      if (bus.in_valid_i && bus.in_ready_o)
        sb_q.push_back('{res: exp_res, tag: bus.tag_i, cyc: cyc});
      if (bus.out_valid_o) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", 32'(bus.out_valid_o), 32'd0);
        end else begin
          e_mon = sb_q[0];
          check("result", 32'(bus.result_o), 32'(e_mon.res));
          check("tag", 32'(bus.tag_o), 32'(e_mon.tag));
          if (bus.out_ready_i) begin
            if (chk_lat) check("latency", 32'(cyc - e_mon.cyc), 32'd3);
            void'(sb_q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                      input logic [15:0] e);
    logic ok;
    ok = 1'b0;
    bus.in_valid_i    = 1'b1;
    bus.operands_i[1] = a;
    bus.operands_i[0] = b;
    bus.tag_i         = t;
    exp_res           = e;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready_o) ok = 1'b1;
      @(posedge clk);
      #1;
      if (toggle) bus.out_ready_i = ~bus.out_ready_i;
    end
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && (sb_q.size() != 0 || bus.out_valid_o); k++) begin
      @(posedge clk);
      #1;
      if (toggle) bus.out_ready_i = ~bus.out_ready_i;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst_ni          = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.operands_i  = '0;
    bus.tag_i       = '0;
    bus.out_ready_i = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_result", 32'(bus.result_o), 32'h0000);
    check("rst_tag", 32'(bus.tag_o), 32'd0);
    #9 rst_ni = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk);
    #1;

    // Directed arithmetic and special values, streamed back to back
    chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) send(dir_a[i], dir_b[i], 4'(i), dir_r[i]);
    wait_drain();

    // Backpressure: three fill the pipe, the fourth must wait
    chk_lat = 1'b0;
    n0 = n_out;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(dir_a[i + 3], dir_b[i + 3], 4'(i), dir_r[i + 3]);
    bus.in_valid_i    = 1'b1;
    bus.operands_i[1] = dir_a[6];
    bus.operands_i[0] = dir_b[6];
    bus.tag_i         = 4'd3;
    exp_res           = dir_r[6];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
      @(posedge clk);
      #1;
    end
    toggle = 1'b1;
    for (int i = 3; i < 6; i++) send(dir_a[i + 3], dir_b[i + 3], 4'(i), dir_r[i + 3]);
    wait_drain();
    toggle = 1'b0;
    bus.out_ready_i = 1'b1;
    check("bp_count", 32'(n_out - n0), 32'd6);

    // Reset with two entries in flight, the first already presented
    bus.out_ready_i = 1'b0;
    send(16'h3C00, 16'h3800, 4'd8, 16'h3800);
    send(16'h3C00, 16'hBC00, 4'd9, 16'h4000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("mid_rst_result", 32'(bus.result_o), 32'h0000);
    sb_q.delete();
    #1 rst_ni = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(bus.out_valid_o), 32'd0);
      check("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    end
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    n0 = n_out;
    send(16'h3C00, 16'h3800, 4'd10, 16'h3800);
    wait_drain();
    check("post_rst_count", 32'(n_out - n0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
